// File: rtl/instr_encoder.sv
// instr_encoder: packs mnemonic requests into 32-bit instruction words,
// expands the nand/or pseudo-ops and streams the words out via a FIFO.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [15:0]      in_imm,
    input  logic [25:0]      in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err_illegal,
    output logic [CNT_W-1:0] issued_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_SW   = 4'd2;
    localparam logic [3:0] OP_JR   = 4'd3;
    localparam logic [3:0] OP_JAL  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_NORI = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_BLEU = 4'd8;
    localparam logic [3:0] OP_ROLV = 4'd9;
    localparam logic [3:0] OP_RORV = 4'd10;
    localparam logic [3:0] OP_NAND = 4'd11;
    localparam logic [3:0] OP_OR   = 4'd12;

    localparam logic [5:0] OPC_AND  = 6'b100000;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;
    localparam logic [5:0] OPC_JR   = 6'b001000;
    localparam logic [5:0] OPC_JAL  = 6'b000011;
    localparam logic [5:0] OPC_NOR  = 6'b100110;
    localparam logic [5:0] OPC_NORI = 6'b001110;
    localparam logic [5:0] OPC_NOT  = 6'b000100;
    localparam logic [5:0] OPC_BLEU = 6'b010000;
    localparam logic [5:0] OPC_ROLV = 6'b000000;
    localparam logic [5:0] OPC_RORV = 6'b000010;

    typedef enum logic {
        IDLE,
        EXPAND
    } state_t;

    state_t state, state_nx;

    logic [31:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [4:0]    rd_q, rd_nx;

    logic [5:0]  opc;
    logic        is_r, is_i, is_not, is_jr, is_jal;
    logic        illegal, is_pseudo;
    logic        accept, push, pop, err_nx;
    logic [31:0] enc_word, not_word, push_word;

    // Operation select -> opcode plus field-format class
    always_comb begin
        opc       = 6'b0;
        is_r      = 1'b0;
        is_i      = 1'b0;
        is_not    = 1'b0;
        is_jr     = 1'b0;
        is_jal    = 1'b0;
        illegal   = 1'b0;
        is_pseudo = 1'b0;
        case (in_op)
            OP_AND:  begin opc = OPC_AND;  is_r = 1'b1; end
            OP_LW:   begin opc = OPC_LW;   is_i = 1'b1; end
            OP_SW:   begin opc = OPC_SW;   is_i = 1'b1; end
            OP_JR:   begin opc = OPC_JR;   is_jr = 1'b1; end
            OP_JAL:  begin opc = OPC_JAL;  is_jal = 1'b1; end
            OP_NOR:  begin opc = OPC_NOR;  is_r = 1'b1; end
            OP_NORI: begin opc = OPC_NORI; is_i = 1'b1; end
            OP_NOT:  begin opc = OPC_NOT;  is_not = 1'b1; end
            OP_BLEU: begin opc = OPC_BLEU; is_i = 1'b1; end
            OP_ROLV: begin opc = OPC_ROLV; is_r = 1'b1; end
            OP_RORV: begin opc = OPC_RORV; is_r = 1'b1; end
            OP_NAND: begin
                opc       = OPC_AND;
                is_r      = 1'b1;
                is_pseudo = 1'b1;
            end
            OP_OR: begin
                opc       = OPC_NOR;
                is_r      = 1'b1;
                is_pseudo = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        enc_word = 32'b0;
        unique case (1'b1)
            is_r:    enc_word = {opc, in_rs, in_rt, in_rd, 11'b0};
            is_not:  enc_word = {opc, in_rs, 5'b0, in_rd, 11'b0};
            is_i:    enc_word = {opc, in_rs, in_rt, in_imm};
            is_jr:   enc_word = {opc, in_rs, 21'b0};
            is_jal:  enc_word = {opc, in_target};
            default: enc_word = 32'b0;
        endcase
    end

    // Second word of both pseudo-ops: not rd,rd
    assign not_word = {OPC_NOT, rd_q, 5'b0, rd_q, 11'b0};

    assign out_valid = (count != '0);
    assign out_instr = out_valid ? mem[rd_ptr] : 32'b0;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_nx  = state;
        rd_nx     = rd_q;
        in_ready  = 1'b0;
        accept    = 1'b0;
        push      = 1'b0;
        push_word = enc_word;
        unique case (state)
            IDLE: begin
                in_ready = reset_n && (count < FULL);
                accept   = in_valid && in_ready;
                push     = accept && !illegal;
                if (accept && is_pseudo) begin
                    state_nx = EXPAND;
                    rd_nx    = in_rd;
                end
            end
            EXPAND: begin
                push_word = not_word;
                if ((count < FULL) || pop) begin
                    push     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign err_nx = accept && illegal;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            rd_q         <= 5'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_illegal  <= 1'b0;
            issued_count <= '0;
        end else begin
            state       <= state_nx;
            rd_q        <= rd_nx;
            err_illegal <= err_nx;
            count       <= count + CW'(push) - CW'(pop);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + PW'(1);
                issued_count <= issued_count + CNT_W'(1);
            end
        end
    end

    // Storage is unreset; visibility is governed by count
    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            mem[wr_ptr] <= push_word;
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Producer end of the instruction-word interface: packs mnemonic-level requests (operation select plus register/immediate/target fields) into 32-bit instruction words in the format the control decoder consumes.
- Expands the two pseudo-ops (nand, or) into two-word sequences.
- Buffers encoded words in a small FIFO and emits them over a valid/ready stream toward instruction memory or the program loader.

Parameters:
DEPTH, 4, output FIFO depth in words (power of two, >=2)
CNT_W, 16, width of issued-word counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  encoder can accept a request this cycle
in_op  in  4  operation select (encoding below)
in_rs  in  5  source register rs
in_rt  in  5  source register rt
in_rd  in  5  destination register rd
in_imm  in  16  immediate (lw, sw, nori, bleu offset)
in_target  in  26  jump target (jal)
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer takes head this cycle
out_instr  out  32  FIFO head instruction word
err_illegal  out  1  one-cycle pulse: illegal in_op accepted
issued_count  out  CNT_W  total words popped since reset, wraps

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-low, reset_n.
- in_op map: 0 and, 1 lw, 2 sw, 3 jr, 4 jal, 5 nor, 6 nori, 7 not, 8 bleu, 9 rolv, 10 rorv, 11 nand (pseudo), 12 or (pseudo), 13-15 illegal.
- Opcode (instr[31:26]):
  - and 100000, lw 100011, sw 101011, jr 001000, jal 000011
  - nor 100110, nori 001110, not 000100, bleu 010000, rolv 000000, rorv 000010
- Field layout:
  - R-type (and, nor, rolv, rorv): op|rs[25:21]|rt[20:16]|rd[15:11]|0[10:0]
  - not: R-type with rt field forced 0
  - I-type (lw, sw, nori, bleu): op|rs|rt|imm[15:0]
  - jr: op|rs|0[20:0]
  - jal: op|target[25:0]
- Pseudo expansion:
  - nand: word1 = and rd,rs,rt; word2 = not rd,rd (rs field = rd, rt = 0, rd = rd)
  - or: word1 = nor rd,rs,rt; word2 = not rd,rd
- FSM states: IDLE, EXPAND.
  - IDLE: in_ready = (count < DEPTH).
  - Accept = in_valid & in_ready.
  - On accepting a legal non-pseudo op: push one word, stay in IDLE.
  - On accepting a pseudo op: push word1, latch rd, go to EXPAND.
  - On accepting an illegal op: no push; err_illegal = 1 next cycle for exactly one cycle; stay in IDLE.
  - EXPAND: in_ready = 0. Push word2 in the first cycle with space (count < DEPTH, or count == DEPTH with a simultaneous pop), then return to IDLE. Word2 always directly follows word1 in the FIFO.
- FIFO:
  - Registered storage; out_instr = head word; out_valid = (count != 0).
  - Push into an empty FIFO is visible on out_valid the next cycle (1-cycle latency).
  - Pop = out_valid & out_ready. A simultaneous push and pop leaves count unchanged and is legal even when full.
  - out_instr holds stable while out_valid & ~out_ready.
  - Pointers wrap modulo DEPTH.
- issued_count increments on every pop and wraps 2^CNT_W-1 -> 0.
- Reset (reset_n = 0 at a clock edge), including mid-expansion:
  - State -> IDLE; FIFO emptied (count 0, pointers 0); any pending word2 is discarded.
  - out_valid 0, out_instr 0, err_illegal 0, issued_count 0; in_ready 0 during reset.
  - in_ready = 1 the first cycle after reset release.

Test Plan:
- Reset, then and rs=1 rt=2 rd=3 with out_ready=1 -> out_instr 0x80221800 one cycle after accept; issued_count = 1.
- jal target=0x0000040, then lw rs=4 rt=5 imm=0x0010 -> 0x0C000040 then 0x8C850010, in order.
- nand rs=1 rt=2 rd=3 -> 0x80221800 then 0x10601800 on consecutive pops; in_ready low for the EXPAND cycle.
- out_ready=0, issue 4 rolv -> count 4, in_ready 0. Then out_ready=1 with in_valid held -> sustained push+pop, one word per cycle, no loss or duplication.
- in_op=14 -> no word produced, err_illegal high exactly one cycle, in_ready stays 1.
- or with FIFO at DEPTH-1, assert reset_n=0 while in EXPAND -> FIFO empty, out_valid 0, no word2 emitted after release, issued_count 0.
